tff_toggle_arbiter: RTL and testbench
=====================================

Name: tff_toggle_arbiter

Overview:
- Owns a bank of WIDTH toggle flip-flops and shares it among NREQ requesters.
- Each requester presents a toggle mask with a request.
- A round-robin arbiter grants at most one requester per clock, and that requester's mask is XOR-applied to the bank.
- Used wherever several agents must flip shared status/phase bits without racing one another.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of toggle flip-flops in the bank.
- CNTW, 16, width of the saturating applied-toggle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of bank and counter.
- req  input  NREQ  per-requester toggle request, level.
- mask  input  NREQ*WIDTH  per-requester toggle mask; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant pulse.
- q  output  WIDTH  toggle-bank state.
- busy  output  1  high when any req bit is pending and not currently granted (combinational).
- toggle_cnt  output  CNTW  count of grants with nonzero mask, saturating.

Behaviour:
- Reset (rstn low, asynchronous): q=0, gnt=0, toggle_cnt=0, round-robin pointer ptr=0. Release is synchronous to clk by the environment.
- Eligibility: eligible[i] = req[i] & ~gnt[i]. A requester granted in the current cycle cannot win at the next edge, so it never gets back-to-back grants.
- Arbitration at each rising edge, when clr=0 and eligible is nonzero:
  - winner w = first eligible index searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - gnt <= one-hot(w).
  - q <= q ^ mask[w].
  - ptr <= (w+1) mod NREQ.
  - If mask[w] != 0 and toggle_cnt != all-ones: toggle_cnt <= toggle_cnt+1.
- When clr=0 and nothing is eligible: gnt <= 0; q, ptr and toggle_cnt hold.
- clr=1 at an edge: q <= 0, toggle_cnt <= 0, gnt <= 0, ptr holds. No grant is issued, and requests remain pending for later edges.
- Latency: mask sampled at edge E; the new q and the gnt pulse are both visible after E. Toggle-to-output latency is one cycle.
- Handshake:
  - req must be held, with a stable mask, until the requester sees gnt high.
  - The requester may drop req or present a new mask during its gnt cycle; the arbiter ignores it for that edge.
  - If req is still high after the gnt cycle, it is treated as a new request.
  - Dropping req before grant withdraws the request with no toggle.
- Zero mask: a grant still issues and ptr still advances; q is unchanged and toggle_cnt is not incremented.
- Single requester held high continuously: granted every other cycle (grant, ineligible, grant, ...).
- Saturation: toggle_cnt sticks at 2^CNTW-1 until clr or reset.
- Reset mid-operation: all state is cleared immediately and any in-flight gnt pulse is killed.
- busy = |(req & ~gnt).
- Width rule: the winner index uses ceil(log2(NREQ)) bits. Wrap-around is computed explicitly, not by relying on power-of-two NREQ.

Test Plan:
- Reset: assert rstn=0 mid-cycle with req=4'b1111 active -> q=0, gnt=0, toggle_cnt=0 immediately, without waiting for a clock edge.
- Single toggle: req=4'b0010, mask1=8'hA5; release req on gnt -> gnt=4'b0010 for exactly 1 cycle, q=8'hA5, toggle_cnt=1.
- Round-robin: req=4'b1111 held, masks 8'h01/02/04/08.
  - Grants follow 0,1,2,3,0,... with no index repeated in consecutive cycles.
  - After 4 grants q=8'h0F; after 8 grants q=8'h00.
- Hog check: req0 held high with mask 8'hFF, others idle -> gnt0 pulses every other cycle; q alternates 8'hFF/8'h00 on each grant; toggle_cnt increments per grant.
- Clear collision: clr=1 at the same edge req2 is pending with mask 8'h3C -> no gnt and q=0; next edge gnt=4'b0100 and q=8'h3C.
- Edge cases:
  - Zero-mask grant advances ptr without counting.
  - With CNTW=4, 20 nonzero grants -> toggle_cnt=4'hF.
  - Withdrawing req before grant -> no gnt and q unchanged.

Source files
------------

// File: rtl/tff_toggle_arbiter.sv
// Bank of WIDTH toggle flip-flops shared by NREQ requesters through a round-robin arbiter.
// At most one grant per clock; the winner's mask is XOR-applied to the bank.
module tff_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [CNTW-1:0]       toggle_cnt
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [WIDTH-1:0] bank_q, bank_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [NREQ-1:0]  eligible;
  logic [WIDTH-1:0] req_mask [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_mask[gi] = mask[gi*WIDTH +: WIDTH];
      assign eligible[gi] = req[gi] & ~gnt_q[gi];
    end
  endgenerate

  // Rotating search from ptr; the wrap subtracts NREQ so non-power-of-two NREQ works.
  logic             found;
  logic [IDXW-1:0]  win;
  logic [IDXW-1:0]  idx;
  logic [IDXW:0]    idx_w;
  logic [WIDTH-1:0] win_mask;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    idx_w    = '0;
    win_mask = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (idx_w >= (IDXW+1)'(NREQ)) begin
        idx_w = idx_w - (IDXW+1)'(NREQ);
      end
      idx = idx_w[IDXW-1:0];
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        win      = idx;
        win_mask = req_mask[idx];
      end
    end
  end

  always_comb begin
    bank_d = bank_q;
    gnt_d  = '0;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      // Requests stay pending; the pointer keeps its place in the rotation.
      bank_d = '0;
      cnt_d  = '0;
    end else if (found) begin
      gnt_d[win] = 1'b1;
      bank_d     = bank_q ^ win_mask;
      ptr_d      = (win == IDXW'(NREQ-1)) ? '0 : win + IDXW'(1);
      if ((|win_mask) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_q <= '0;
      gnt_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      bank_q <= bank_d;
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign q          = bank_q;
  assign toggle_cnt = cnt_q;
  assign busy       = |(req & ~gnt_q);

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed and random stimulus for tff_toggle_arbiter, checked against a rule-level model.
// A second instance with a 4-bit counter exercises saturation on the same stimulus.
module tb_tff_toggle_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       gnt, gnt4;
  logic [WIDTH-1:0]      q, q4;
  logic                  busy, busy4;
  logic [15:0]           toggle_cnt;
  logic [3:0]            toggle_cnt4;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  int               m_ptr, m_cnt, m_cnt4;

  always #5 clk = ~clk;

  tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(16)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .req(req), .mask(mask),
    .gnt(gnt), .q(q), .busy(busy), .toggle_cnt(toggle_cnt)
  );

  tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(4)) dut_sat (
    .clk(clk), .rstn(rstn), .clr(clr), .req(req), .mask(mask),
    .gnt(gnt4), .q(q4), .busy(busy4), .toggle_cnt(toggle_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_gnt = '0; m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"},    32'(q),           32'(m_q));
    check({tag, "_gnt"},  32'(gnt),         32'(m_gnt));
    check({tag, "_cnt"},  32'(toggle_cnt),  32'(m_cnt));
    check({tag, "_cnt4"}, 32'(toggle_cnt4), 32'(m_cnt4));
    check({tag, "_q4"},   32'(q4),          32'(m_q));
    check({tag, "_busy"}, 32'(busy),        32'(|(req & ~m_gnt)));
  endtask

  // One clock: predict from the rules, advance, then compare 1 ns after the edge.
  task automatic tick(input string tag);
    int w;
    logic [WIDTH-1:0] mk;
    w = -1;
    if (clr) begin
      m_q = '0; m_cnt = 0; m_cnt4 = 0; m_gnt = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (w < 0 && req[i] && !m_gnt[i]) w = i;
      end
      if (w < 0) begin
        m_gnt = '0;
      end else begin
        mk    = mask[w*WIDTH +: WIDTH];
        m_q   = m_q ^ mk;
        m_gnt = NREQ'(1) << w;
        m_ptr = (w + 1) % NREQ;
        if (mk != 0) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
      end
    end
    @(posedge clk);
    #1;
    $display("%s: req=%b clr=%b gnt=%b q=%h cnt=%0d cnt4=%0d", tag, req, clr, gnt, q, toggle_cnt, toggle_cnt4);
    check_all(tag);
  endtask

  // Pull rstn low between edges and expect everything cleared without a clock.
  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    $display("%s: async reset req=%b gnt=%b q=%h cnt=%0d", tag, req, gnt, q, toggle_cnt);
    check_all(tag);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; req = '0; mask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("por");
    rstn = 1'b1;

    // Single toggle, released on grant
    req = 4'b0010; mask = '0; mask[15:8] = 8'hA5;
    tick("single");
    check("single_gnt_exp", 32'(gnt), 32'h2);
    check("single_q_exp", 32'(q), 32'hA5);
    req = '0;
    tick("single_after");

    // Round robin with all four requesters held
    async_reset("rst_before_rr");
    req = 4'b1111; mask = {8'h08, 8'h04, 8'h02, 8'h01};
    for (int k = 0; k < 8; k++) begin
      tick("rr");
      check("rr_order", 32'(gnt), 32'(1 << (k % 4)));
      if (k == 3) check("rr4_q", 32'(q), 32'h0F);
    end
    check("rr8_q", 32'(q), 32'h00);
    tick("rr_more");
    async_reset("rst_mid_rr");

    // Hog: one requester held continuously
    req = 4'b0001; mask = '0; mask[7:0] = 8'hFF;
    for (int k = 0; k < 6; k++) tick("hog");
    req = '0;
    tick("hog_idle");

    // Clear colliding with a pending request
    req = 4'b0100; mask = '0; mask[23:16] = 8'h3C; clr = 1'b1;
    tick("clr_coll");
    check("clr_gnt_exp", 32'(gnt), 32'h0);
    clr = 1'b0;
    tick("clr_next");
    check("clr_next_q_exp", 32'(q), 32'h3C);
    req = '0;
    tick("clr_idle");

    // Zero-mask grant advances the pointer without counting
    async_reset("rst_zero");
    req = 4'b0001; mask = '0;
    tick("zero");
    req = '0;
    tick("zero_idle");
    req = 4'b0011; mask = {16'h0, 8'h02, 8'h01};
    tick("zero_ptr");
    check("zero_ptr_exp", 32'(gnt), 32'h2);
    req = '0;
    tick("zero_done");

    // Saturation of the 4-bit counter: 20 nonzero grants
    async_reset("rst_sat");
    req = 4'b0011; mask = {16'h0, 8'h02, 8'h01};
    for (int k = 0; k < 20; k++) tick("sat");
    check("sat_cnt4_exp", 32'(toggle_cnt4), 32'hF);
    check("sat_cnt_exp", 32'(toggle_cnt), 32'd20);

    // Withdraw a request before it is granted
    async_reset("rst_wd");
    req = 4'b0011; mask = {16'h0, 8'h40, 8'h01};
    tick("wd_first");
    req = '0;
    tick("wd_drop");
    check("wd_q_exp", 32'(q), 32'h01);

    // Random traffic, occasional clear and asynchronous reset
    for (int n = 0; n < 400; n++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        mask[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      clr = ($urandom_range(0, 15) == 0);
      tick("rand");
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
